// File: rtl/sd_spi_responder.sv
// SPI-mode SD-card responder: decodes command frames from the divmmc SPI master and
// serves single-block reads from a 512-byte buffer filled by the host side.
module sd_spi_responder #(
  parameter int SDHC       = 1,
  parameter int INIT_POLLS = 2
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        sd_cs,
  input  logic        sd_sck,
  input  logic        sd_sdi,
  output logic        sd_sdo,
  output logic [31:0] io_lba,
  output logic        io_rd,
  input  logic        io_ack,
  input  logic [7:0]  io_din,
  input  logic        io_din_strobe,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RESP, S_RDREQ, S_RDWAIT, S_TOKEN, S_DATA, S_CRC
  } state_t;

  localparam logic [31:0] OCR        = (SDHC != 0) ? 32'hC0FF_8000 : 32'h80FF_8000;
  localparam logic [7:0]  POLL_LIMIT = 8'(INIT_POLLS);

  state_t      state_q, state_d;
  logic [1:0]  cs_sync_q, sck_sync_q, sdi_sync_q;
  logic        sck_prev_q, ack_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [6:0]  tx_q, tx_d;
  logic        sdo_q, sdo_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  resp_cnt_q, resp_cnt_d;
  logic        is_read_q, is_read_d;
  logic        idle_flag_q, idle_flag_d;
  logic        app_flag_q, app_flag_d;
  logic [7:0]  polls_q, polls_d;
  logic        io_rd_q, io_rd_d;
  logic [31:0] io_lba_q, io_lba_d;
  logic        busy_q, busy_d;
  logic        rd_active_q, rd_active_d;
  logic [8:0]  wptr_q, wptr_d;
  logic [8:0]  rptr_q, rptr_d;
  logic [1:0]  crc_cnt_q, crc_cnt_d;

  logic [7:0]  buf_mem [512];

  logic        cs_n, sck_rise, sck_fall, byte_done;
  logic [7:0]  rx_byte, next_tx, polls_inc;
  logic        illegal, new_idle;
  logic [2:0]  len;
  logic [31:0] tail, lba;

  assign cs_n      = cs_sync_q[1];
  assign sck_rise  = !cs_n && sck_sync_q[1] && !sck_prev_q;
  assign sck_fall  = !cs_n && !sck_sync_q[1] && sck_prev_q;
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, sdi_sync_q[1]};
  assign lba       = (SDHC != 0) ? arg_q : {9'd0, arg_q[31:9]};

  // NOTE: every variable below gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    sdo_d       = sdo_q;
    cmd_idx_d   = cmd_idx_q;
    arg_d       = arg_q;
    byte_cnt_d  = byte_cnt_q;
    resp_d      = resp_q;
    resp_cnt_d  = resp_cnt_q;
    is_read_d   = is_read_q;
    idle_flag_d = idle_flag_q;
    app_flag_d  = app_flag_q;
    polls_d     = polls_q;
    io_lba_d    = io_lba_q;
    busy_d      = busy_q;
    rd_active_d = rd_active_q;
    rptr_d      = rptr_q;
    crc_cnt_d   = crc_cnt_q;
    next_tx     = 8'hFF;
    polls_inc   = polls_q;
    illegal     = 1'b0;
    new_idle    = idle_flag_q;
    len         = 3'd1;
    tail        = 32'd0;

    // A pending request is released only by the host, even across an abort.
    io_rd_d = io_rd_q && !io_ack;
    wptr_d  = (io_din_strobe && rd_active_q) ? wptr_q + 9'd1 : wptr_q;

    if (cs_n) begin
      bit_cnt_d   = 3'd0;
      sdo_d       = 1'b1;
      tx_d        = 7'h7F;
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      rd_active_d = 1'b0;
    end else begin
      if (sck_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // The fall right after a byte boundary must not shift: the new MSB is already on sd_sdo.
      if (sck_fall && bit_cnt_q != 3'd0) begin
        sdo_d = tx_q[6];
        tx_d  = {tx_q[5:0], 1'b1};
      end

      if (byte_done) begin
        case (state_q)
          S_IDLE: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_idx_d  = rx_byte[5:0];
              byte_cnt_d = 3'd0;
              state_d    = S_CMD;
            end
          end
          S_CMD: begin
            if (byte_cnt_q != 3'd4) begin
              arg_d      = {arg_q[23:0], rx_byte};
              byte_cnt_d = byte_cnt_q + 3'd1;
            end else begin
              app_flag_d = 1'b0;
              is_read_d  = 1'b0;
              case (cmd_idx_q)
                6'd0: begin
                  new_idle = 1'b1;
                  polls_d  = 8'd0;
                end
                6'd8: begin
                  len  = 3'd5;
                  tail = {20'd0, arg_q[11:0]};
                end
                6'd16: ;
                6'd17: begin
                  if (!idle_flag_q) begin
                    is_read_d = 1'b1;
                    busy_d    = 1'b1;
                  end else begin
                    illegal = 1'b1;
                  end
                end
                6'd41: begin
                  if (app_flag_q) begin
                    polls_inc = (polls_q == 8'hFF) ? polls_q : polls_q + 8'd1;
                    polls_d   = polls_inc;
                    if (polls_inc > POLL_LIMIT) new_idle = 1'b0;
                  end else begin
                    illegal = 1'b1;
                  end
                end
                6'd55: app_flag_d = 1'b1;
                6'd58: begin
                  len  = 3'd5;
                  tail = OCR;
                end
                default: illegal = 1'b1;
              endcase
              idle_flag_d = new_idle;
              resp_d      = {5'd0, illegal, 1'b0, new_idle, tail};
              resp_cnt_d  = len;
              state_d     = S_RESP;
            end
          end
          S_RESP: begin
            if (resp_cnt_q != 3'd0) begin
              next_tx    = resp_q[39:32];
              resp_d     = {resp_q[31:0], 8'h00};
              resp_cnt_d = resp_cnt_q - 3'd1;
            end else if (is_read_q) begin
              state_d     = S_RDREQ;
              io_rd_d     = 1'b1;
              io_lba_d    = lba;
              wptr_d      = 9'd0;
              rd_active_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_TOKEN: begin
            next_tx = 8'hFE;
            rptr_d  = 9'd0;
            state_d = S_DATA;
          end
          S_DATA: begin
            next_tx = buf_mem[rptr_q];
            rptr_d  = rptr_q + 9'd1;
            if (rptr_q == 9'd511) begin
              crc_cnt_d = 2'd0;
              state_d   = S_CRC;
            end
          end
          S_CRC: begin
            crc_cnt_d = crc_cnt_q + 2'd1;
            if (crc_cnt_q == 2'd2) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
          default: ;
        endcase
        tx_d  = next_tx[6:0];
        sdo_d = next_tx[7];
      end

      // Host handshake progresses on clk, independent of SPI byte boundaries.
      case (state_q)
        S_RDREQ:  if (io_ack) state_d = S_RDWAIT;
        S_RDWAIT: begin
          if (ack_prev_q && !io_ack) begin
            state_d     = S_TOKEN;
            rd_active_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      sdi_sync_q  <= 2'b11;
      sck_prev_q  <= 1'b0;
      ack_prev_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 7'h7F;
      sdo_q       <= 1'b1;
      cmd_idx_q   <= 6'd0;
      arg_q       <= 32'd0;
      byte_cnt_q  <= 3'd0;
      resp_q      <= 40'd0;
      resp_cnt_q  <= 3'd0;
      is_read_q   <= 1'b0;
      idle_flag_q <= 1'b1;
      app_flag_q  <= 1'b0;
      polls_q     <= 8'd0;
      io_rd_q     <= 1'b0;
      io_lba_q    <= 32'd0;
      busy_q      <= 1'b0;
      rd_active_q <= 1'b0;
      wptr_q      <= 9'd0;
      rptr_q      <= 9'd0;
      crc_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= {cs_sync_q[0], sd_cs};
      sck_sync_q  <= {sck_sync_q[0], sd_sck};
      sdi_sync_q  <= {sdi_sync_q[0], sd_sdi};
      sck_prev_q  <= sck_sync_q[1];
      ack_prev_q  <= io_ack;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      sdo_q       <= sdo_d;
      cmd_idx_q   <= cmd_idx_d;
      arg_q       <= arg_d;
      byte_cnt_q  <= byte_cnt_d;
      resp_q      <= resp_d;
      resp_cnt_q  <= resp_cnt_d;
      is_read_q   <= is_read_d;
      idle_flag_q <= idle_flag_d;
      app_flag_q  <= app_flag_d;
      polls_q     <= polls_d;
      io_rd_q     <= io_rd_d;
      io_lba_q    <= io_lba_d;
      busy_q      <= busy_d;
      rd_active_q <= rd_active_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      crc_cnt_q   <= crc_cnt_d;
    end
  end

  // NOTE: the sector buffer has no reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (io_din_strobe && rd_active_q) buf_mem[wptr_q] <= io_din;
  end

  assign sd_sdo = sdo_q;
  assign io_rd  = io_rd_q;
  assign io_lba = io_lba_q;
  assign busy   = busy_q;

endmodule
